// File: rtl/psum_pkg.sv
// Shared types and defaults for the partial-sum accumulator slice.
// No logic here; widths, FSM state encoding and a lane-slicing helper.
// Backpressure: n/a.
package psum_pkg;

  localparam int PSUM_W_DEF = 24;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } psum_state_e;

  // LSB position of lane 'lane' in a bus of equal-width lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/psum_deskew.sv
// Fixed-length delay line used to undo the per-column skew of the PE array.
// Latency: DELAY cycles; DELAY = 0 is a straight wire.
// Backpressure: none, the line shifts every cycle in every state.
module psum_deskew #(
  parameter int DELAY = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DELAY == 0) begin : g_wire
    // Clock and reset are not needed for a zero-length line.
    logic unused_ok;
    assign unused_ok = clk ^ rst_n;
    assign dout      = din;
  end else begin : g_pipe
    logic [W-1:0] stage [DELAY];

    // Shift register: stage 0 takes the input, the last stage is the output.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DELAY; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DELAY-1];
  end

endmodule

// File: rtl/psum_accumulator.sv
// Deskews PE-array psum rows, accumulates them over num_pass tile passes, then drains rows.
// Latency: lane-0 psum lands in the buffer COLS-1 cycles later; first drained row 1 cycle after last write.
// Backpressure: drain output registers hold while out_valid && !out_ready; input cannot be stalled (drops flag err_overrun).
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            num_pass,
  input  logic                  in_valid,
  input  logic [COLS*PSUM_W-1:0] psum_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_overrun
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  psum_state_e state;
  psum_state_e state_nxt;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_inc;
  logic [PTR_W-1:0] load_idx;
  logic [7:0]       pass_cnt;
  logic [7:0]       num_pass_r;
  logic             wr_last;
  logic             pass_last;
  logic             accum_en;
  logic             xfer;

  logic [PSUM_W-1:0]      aligned_psum [COLS];
  logic                   aligned_valid;
  logic [ACC_W-1:0]       acc [DEPTH][COLS];
  logic [COLS*ACC_W-1:0]  load_row;

  // Valid travels through the longest lane delay so it lines up with every lane.
  psum_deskew #(.DELAY(COLS - 1), .W(1)) u_valid_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (in_valid),
    .dout (aligned_valid)
  );

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    psum_deskew #(.DELAY(COLS - 1 - c), .W(PSUM_W)) u_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (psum_in[lane_lsb(c, PSUM_W) +: PSUM_W]),
      .dout (aligned_psum[c])
    );
  end

  assign wr_last   = (wr_ptr == PTR_LAST);
  assign pass_last = (pass_cnt == num_pass_r - 8'd1);
  assign accum_en  = (state == ACCUM) && aligned_valid;
  assign xfer      = out_valid && out_ready;
  assign rd_inc    = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
  // First beat loads rd_ptr; after a transfer the next row is loaded directly.
  assign load_idx  = out_valid ? rd_inc : rd_ptr;
  assign busy      = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: start, last write of the last pass, last drain transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accum_en && wr_last && pass_last) state_nxt = DRAIN;
      DRAIN:   if (xfer && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gather the row that the drain registers will load next.
  always_comb begin
    load_row = '0;
    for (int c = 0; c < COLS; c++) begin
      load_row[lane_lsb(c, ACC_W) +: ACC_W] = acc[load_idx][c];
    end
  end

  // Accumulator buffer: pass 0 overwrites so stale contents never need clearing.
  always_ff @(posedge clk) begin
    if (accum_en) begin
      for (int c = 0; c < COLS; c++) begin
        if (pass_cnt == 8'd0) acc[wr_ptr][c] <= ACC_W'(aligned_psum[c]);
        else                  acc[wr_ptr][c] <= acc[wr_ptr][c] + ACC_W'(aligned_psum[c]);
      end
    end
  end

  // Pointers, pass counting, drain output registers and the overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pass_cnt    <= '0;
      num_pass_r  <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        num_pass_r  <= (num_pass == 8'd0) ? 8'd1 : num_pass;
        wr_ptr      <= '0;
        pass_cnt    <= '0;
        err_overrun <= 1'b0;
      end

      // Rows arriving outside ACCUM are dropped; setting wins over a same-cycle clear.
      if (aligned_valid && state != ACCUM) err_overrun <= 1'b1;

      if (accum_en) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + PTR_W'(1);
        if (wr_last) begin
          pass_cnt <= pass_cnt + 8'd1;
          if (pass_last) rd_ptr <= '0;
        end
      end

      if (state == DRAIN) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= load_row;
          out_last  <= (rd_ptr == PTR_LAST);
        end else if (out_ready) begin
          rd_ptr <= rd_inc;
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else begin
            out_data <= load_row;
            out_last <= (rd_inc == PTR_LAST);
          end
        end
      end
    end
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Collects the 24-bit partial sums leaving the bottom row of the systolic PE array. It removes the per-column diagonal skew and accumulates each output row across multiple weight-tile passes in a local buffer. When the final pass completes, it drains the buffer row by row to the writeback path over a valid/ready handshake. It is the stage directly downstream of the PE array's `partial_sum_out` chain.

## Interface
Parameters:
- COLS, 4: array columns, i.e. psum lanes.
- PSUM_W, 24: width of each incoming partial sum.
- ACC_W, 32: accumulator width per lane; must be >= PSUM_W.
- DEPTH, 8: output rows per tile pass; must be a power of 2.

Ports (one clock; reset is synchronous and active-low):
- clk, in, 1: sole clock; all state updates on its rising edge.
- rst_n, in, 1: synchronous active-low reset.
- start, in, 1: one-cycle pulse that begins a job; honoured only in IDLE.
- num_pass, in, 8: passes to accumulate; sampled on start; 0 is treated as 1.
- in_valid, in, 1: psum row valid, aligned to column 0.
- psum_in, in, COLS*PSUM_W: lane c occupies bits [c*PSUM_W +: PSUM_W]; lane c arrives c cycles after lane 0.
- out_valid, out, 1: a drained row is presented.
- out_ready, in, 1: downstream accepts the row.
- out_data, out, COLS*ACC_W: accumulated row, packed in the same lane order as psum_in.
- out_last, out, 1: marks the final row (DEPTH-1) of the drain.
- busy, out, 1: high whenever the state is not IDLE.
- err_overrun, out, 1: sticky flag meaning a psum row was dropped; cleared by an accepted start.

## Operation
- **States.** IDLE, ACCUM, DRAIN. State updates are registered.
- **IDLE.** On start, latch num_pass, clear wr_ptr and pass_cnt, and go to ACCUM.
- **Deskew.**
  - Lane c is delayed by COLS-1-c register stages.
  - in_valid is delayed by COLS-1 stages to form aligned_valid.
  - Delay registers reset to 0 and run in every state.
- **ACCUM.** On aligned_valid, update acc[wr_ptr] for every lane c:
  - If pass_cnt == 0: acc = zero-extended psum.
  - Otherwise: acc = acc + zero-extended psum, modulo 2^ACC_W. Overflow wraps silently.
- **Pointer and pass counting.**
  - wr_ptr increments on each aligned_valid and wraps from DEPTH-1 to 0.
  - Each wrap increments pass_cnt.
  - A wrap when pass_cnt == num_pass-1 moves the state to DRAIN and clears rd_ptr.
- **DRAIN.**
  - Present acc[rd_ptr] on out_data with out_valid = 1.
  - A transfer occurs when out_valid && out_ready; rd_ptr then increments.
  - A transfer with out_last = 1 returns the state to IDLE.
- **Overrun.**
  - aligned_valid in IDLE or DRAIN sets err_overrun and discards the data.
  - The buffer and the drain are unaffected.
- **Ignored start.** start outside IDLE is ignored and does not clear err_overrun.
- **Simultaneous events.** A start in the same cycle as the last DRAIN transfer is ignored, because the state is still DRAIN in that cycle.

## Timing
- **Reset values.** All outputs are 0 after reset: out_valid, out_last, busy, err_overrun, out_data. The state is IDLE, pointers and counters are 0, and the delay lines are 0.
- **Reset mid-operation.** Reset in any state returns to these values on the next edge. Accumulator contents are don't-care, since pass 0 overwrites them.
- **busy.** Rises the cycle after start.
- **Input latency.** A lane-0 psum sampled at cycle t is written to acc at edge t+COLS-1.
- **Drain start.** out_valid rises the cycle after the final accumulate write.
- **Drain output registers.** out_data, out_valid and out_last are registered and held stable while out_valid && !out_ready.
- **Drain throughput.** With out_ready held high, the drain delivers one row per cycle: DEPTH beats, back to back.
- **Back-to-back rows.** Consecutive aligned_valid cycles to the same row across passes are legal. Write-after-write is resolved by the registered update; no forwarding is needed.

## Structure
- **Package psum_pkg:**
  - state enum: IDLE, ACCUM, DRAIN.
  - default widths: PSUM_W = 24, ACC_W = 32.
  - lane slice helper function.
- **Sub-module psum_deskew.** One parameterised delay line (DELAY, W), instantiated once per lane plus once for valid. DELAY = 0 is a wire.
- **Accumulator buffer.** A register array of DEPTH x COLS x ACC_W, with no RAM macro.

## Test plan
- **Reset.** Assert rst_n = 0 for 3 cycles mid-ACCUM at wr_ptr = 5 → all outputs 0 and busy = 0. A following start with num_pass = 1 and 8 rows completes normally.
- **Single pass.** COLS = 4, DEPTH = 8, num_pass = 1; row r lane c = 100*r + c, fed with lane skew c → 8 beats in which out_data lane c = 100*r + c, out_last only on r = 7, and out_valid rising 1 cycle after the last aligned write.
- **Three passes.** Every psum = 0xFFFFFF → every lane = 0x02FFFFFD. The same run with ACC_W = 24 → 0xFFFFFD (wrap).
- **Backpressure.** out_ready pattern 1,0,0,1,1,0,1… → every row delivered exactly once, in order, with out_data held constant during stalls.
- **Overrun.** in_valid pulse during DRAIN → err_overrun = 1 and drain values unchanged. A start during DRAIN is ignored. The next accepted start clears err_overrun.
- **num_pass = 0.** Behaves identically to num_pass = 1.
